// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a 4-to-1 mux: steps selects 0..3, samples each channel after DWELL cycles.
// Define MUX4_SCAN_CONT_EN for continuous re-scanning after the first start.
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] data_q, data_d;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = done_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = 8'd0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_d[ch_q] = mux_out;
                if (ch_q == 2'd3) begin
                    // Bit 3 comes straight from the input; the shadow update lands on the same edge.
                    data_d  = {mux_out, shadow_q[2:0]};
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    sel_d   = 2'd0;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    sel_d   = ch_q + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                done_d = 1'b0;
`ifdef MUX4_SCAN_CONT_EN
                state_d = SETTLE;
                ch_d    = 2'd0;
                cnt_d   = 8'd0;
                sel_d   = 2'd0;
                busy_d  = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 4'd0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
        end
    end

    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: two instances (DWELL=2 and DWELL=1) each driving a modelled 4-to-1 mux.
module tb_mux4_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] in_v [2];
    logic [1:0] start_v, s1_v, s0_v, busy_v, done_v, mux_v;
    logic [7:0] data_v;
    int         dw [2] = '{2, 1};
    logic [3:0] prev [2];
    int         passed = 0;
    int         total  = 0;

    assign mux_v[0] = in_v[0][{s1_v[0], s0_v[0]}];
    assign mux_v[1] = in_v[1][{s1_v[1], s0_v[1]}];

    mux4_scan_ctrl #(.DWELL(2)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .mux_out(mux_v[0]),
        .s1(s1_v[0]), .s0(s0_v[0]), .busy(busy_v[0]), .done(done_v[0]), .data(data_v[3:0])
    );

    mux4_scan_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mux_out(mux_v[1]),
        .s1(s1_v[1]), .s0(s0_v[1]), .busy(busy_v[1]), .done(done_v[1]), .data(data_v[7:4])
    );

    typedef struct {
        int         w;
        logic [3:0] pat;
        logic [3:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour after the edge that sampled start (edge 0): for edge k < 4*(DWELL+1)
    // the select is k/(DWELL+1) and busy is high; at edge 4*(DWELL+1) done pulses with the pattern.
    task automatic run_scan(input int w, input logic [3:0] pat, input logic [3:0] exp_data, input int ign_k);
        int L;
        L = 4 * (dw[w] + 1);
        in_v[w] = pat;
        start_v[w] = 1'b1;
        tick();
        start_v[w] = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            if (k > 0) tick();
            start_v[w] = (k + 1 == ign_k);
            chk($sformatf("w%0d k%0d sel", w, k), {s1_v[w], s0_v[w]}, (k < L) ? k / (dw[w] + 1) : 0);
            chk($sformatf("w%0d k%0d busy", w, k), busy_v[w], k < L);
            chk($sformatf("w%0d k%0d done", w, k), done_v[w], k == L);
            chk($sformatf("w%0d k%0d data", w, k), data_v[w*4 +: 4], (k >= L) ? exp_data : prev[w]);
        end
        start_v[w] = 1'b0;
        prev[w] = exp_data;
    endtask

    initial begin
        vec_t vecs [6];
        vecs[0] = '{0, 4'b0101, 4'b0101};
        vecs[1] = '{0, 4'b1110, 4'b1110};
        vecs[2] = '{1, 4'b1110, 4'b1110};
        vecs[3] = '{1, 4'b0001, 4'b0001};
        vecs[4] = '{0, 4'b1111, 4'b1111};
        vecs[5] = '{0, 4'b0000, 4'b0000};

        in_v[0] = 4'b0; in_v[1] = 4'b0;
        start_v = 2'b11;
        rst = 1'b1;
        prev[0] = 4'b0; prev[1] = 4'b0;

        // Reset with start held high: reset wins, everything stays idle.
        repeat (2) tick();
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("rst w%0d sel", w), {s1_v[w], s0_v[w]}, 2'b00);
            chk($sformatf("rst w%0d busy", w), busy_v[w], 1'b0);
            chk($sformatf("rst w%0d done", w), done_v[w], 1'b0);
            chk($sformatf("rst w%0d data", w), data_v[w*4 +: 4], 4'b0000);
        end
        rst = 1'b0;
        start_v = 2'b00;
        tick();
        chk("post-rst idle busy", busy_v, 2'b00);

`ifdef MUX4_SCAN_CONT_EN
        in_v[0] = 4'b0101;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            logic exp_done;
            tick();
            if (k == 13) in_v[0] = 4'b0111;
            exp_done = (k >= 12) && ((k - 12) % 13 == 0);
            chk($sformatf("cont k%0d done", k), done_v[0], exp_done);
            chk($sformatf("cont k%0d busy", k), busy_v[0], !exp_done);
            chk($sformatf("cont k%0d data", k), data_v[3:0],
                (k < 12) ? 4'b0000 : (k < 25) ? 4'b0101 : 4'b0111);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cont rst busy", busy_v[0], 1'b0);
`else
        for (int i = 0; i < 6; i++)
            run_scan(vecs[i].w, vecs[i].pat, vecs[i].exp_data, -1);

        for (int i = 0; i < 16; i++) begin
            int         w;
            logic [3:0] p;
            w = int'($urandom_range(0, 1));
            p = 4'($urandom_range(0, 15));
            run_scan(w, p, p, -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // A second start mid-scan is dropped and does not queue another scan.
        run_scan(0, 4'b1001, 4'b1001, 5);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("ignore k%0d done", k), done_v[0], 1'b0);
            chk($sformatf("ignore k%0d busy", k), busy_v[0], 1'b0);
        end

        // Reset sampled at edge 7 of a scan aborts it and clears data.
        in_v[0] = 4'b1111;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (6) tick();
        chk("abort pre busy", busy_v[0], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", busy_v[0], 1'b0);
        chk("abort sel", {s1_v[0], s0_v[0]}, 2'b00);
        chk("abort data", data_v[3:0], 4'b0000);
        chk("abort done", done_v[0], 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick();
            chk($sformatf("abort k%0d done", k), done_v[0], 1'b0);
            chk($sformatf("abort k%0d busy", k), busy_v[0], 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
